// File: rtl/cdc_data_launch_pkg.sv
// cdc_data_launch_pkg: shared width default and FSM state encodings for the CDC launcher
package cdc_data_launch_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/cdc_data_launch_ack_sync.sv
// ack_sync: multi-flop synchronizer bringing the destination acknowledge into the source clock domain
module ack_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] sync_q;

    // CDC: i_async is asynchronous to i_clk; sync_q[0] may go metastable and only sync_q[STAGES-1] is consumed
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], i_async};
    end

    assign o_sync = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_data_launch.sv
// cdc_data_launch: captures a word and launches it across a clock boundary with a four-phase req/ack handshake
module cdc_data_launch
    import cdc_data_launch_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_async_data,
    output logic             o_async_en,
    input  logic             i_async_ack,
    output logic             o_done,
    output logic             o_busy
);

    state_t state, state_next;
    logic   sync_ack;
    logic   capture;
    logic   drop_req;
    logic   finish;

    ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_async(i_async_ack),
        .o_sync (sync_ack)
    );

    // a stale acknowledge still high from a previous handshake blocks new captures
    assign o_ready = (state == IDLE) & ~sync_ack;
    assign o_busy  = (state != IDLE);

    // handshake sequencing: request until ack seen, then wait for ack to drop
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        drop_req   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE:    if (i_valid && !sync_ack) begin capture = 1'b1; state_next = REQ; end
            REQ:     if (sync_ack) begin drop_req = 1'b1; state_next = RELEASE; end
            RELEASE: if (!sync_ack) begin finish = 1'b1; state_next = IDLE; end
            default: state_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    // crossing outputs come straight from flops so the destination never sees a glitch
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_async_data <= '0;
            o_async_en   <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_async_data <= capture ? i_data : o_async_data;
            o_async_en   <= capture | (o_async_en & ~drop_req);
            o_done       <= finish;
        end
    end

endmodule

// File: tb/tb_cdc_data_launch.sv
// tb_cdc_data_launch: randomized self-checking bench for the CDC data launcher
module tb_cdc_data_launch;

    localparam int W = 8;
    localparam int S = 2;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [W-1:0] i_data = '0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [W-1:0] o_async_data;
    logic         o_async_en;
    logic         i_async_ack = 1'b0;
    logic         o_done;
    logic         o_busy;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    cdc_data_launch #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_async_data(o_async_data),
        .o_async_en  (o_async_en),
        .i_async_ack (i_async_ack),
        .o_done      (o_done),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        tick;
        vectors++;
        if (o_async_en !== 1'b0 || o_async_data !== 8'h00 || o_done !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: en=%b data=%h done=%b busy=%b ready=%b, want 0 00 0 0 1", o_async_en, o_async_data, o_done, o_busy, o_ready);
        end
        #2 i_rst = 1'b0;
        tick;
        vectors++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: ready=%b busy=%b, want 1 0", o_ready, o_busy);
        end
    endtask

    // destination model: ack d1 cycles after the request, release ack d2 cycles after request drops
    task automatic run_handshake(input logic [W-1:0] exp, input int d1, input int d2, input bit toggle);
        int n;
        for (int i = 0; i < d1; i++) begin
            if (toggle) begin i_data = W'($urandom); i_valid = 1'($urandom); end
            tick;
            vectors++;
            if (o_async_data !== exp || o_async_en !== 1'b1 || o_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_req: data=%h en=%b ready=%b, want %h 1 0", o_async_data, o_async_en, o_ready, exp);
            end
        end
        i_async_ack = 1'b1;
        got_q.push_back(o_async_data);
        n = 0;
        do begin
            if (toggle) begin i_data = W'($urandom); i_valid = 1'($urandom); end
            tick;
            n++;
        end while (o_async_en === 1'b1 && n < 12);
        vectors++;
        if (n != S + 1 || o_async_en !== 1'b0) begin
            miscompares++;
            $display("FAIL en_fall: edges=%0d en=%b, want %0d 0", n, o_async_en, S + 1);
        end
        for (int i = 0; i < d2; i++) begin
            if (toggle) begin i_data = W'($urandom); i_valid = 1'($urandom); end
            tick;
            vectors++;
            if (o_async_data !== exp || o_async_en !== 1'b0 || o_ready !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_release: data=%h en=%b ready=%b done=%b busy=%b, want %h 0 0 0 1", o_async_data, o_async_en, o_ready, o_done, o_busy, exp);
            end
        end
        i_async_ack = 1'b0;
        n = 0;
        do begin
            if (toggle) begin i_data = W'($urandom); i_valid = 1'($urandom); end
            tick;
            n++;
        end while (o_done !== 1'b1 && n < 12);
        vectors++;
        if (n != S + 1 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_async_data !== exp) begin
            miscompares++;
            $display("FAIL done: edges=%0d ready=%b busy=%b data=%h, want %0d 1 0 %h", n, o_ready, o_busy, o_async_data, S + 1, exp);
        end
    endtask

    task automatic capture_word(input logic [W-1:0] d);
        i_data = d;
        i_valid = 1'b1;
        tick;
        i_valid = 1'b0;
        vectors++;
        if (o_async_en !== 1'b1 || o_async_data !== d || o_ready !== 1'b0 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL capture: en=%b data=%h ready=%b busy=%b, want 1 %h 0 1", o_async_en, o_async_data, o_ready, o_busy, d);
        end
    endtask

    task automatic test_single;
        capture_word(8'hA5);
        exp_q.push_back(8'hA5);
        run_handshake(8'hA5, 3, 3, 1'b0);
        tick;
        vectors++;
        if (o_done !== 1'b0 || o_ready !== 1'b1 || o_async_en !== 1'b0 || o_async_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_end: done=%b ready=%b en=%b data=%h, want 0 1 0 a5", o_done, o_ready, o_async_en, o_async_data);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] w[3];
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
        i_data = w[0];
        i_valid = 1'b1;
        tick;
        exp_q.push_back(w[0]);
        for (int k = 0; k < 3; k++) begin
            if (k < 2) i_data = w[k+1];
            else       i_valid = 1'b0;
            run_handshake(w[k], 2, 2, 1'b0);
            if (k < 2) begin
                tick;
                exp_q.push_back(w[k+1]);
                vectors++;
                if (o_async_data !== w[k+1] || o_async_en !== 1'b1 || o_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_capture: data=%h en=%b done=%b, want %h 1 0", o_async_data, o_async_en, o_done, w[k+1]);
                end
            end
        end
        tick;
        vectors++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_async_data !== 8'h33) begin
            miscompares++;
            $display("FAIL b2b_end: busy=%b done=%b data=%h, want 0 0 33", o_busy, o_done, o_async_data);
        end
    endtask

    task automatic test_ignored_input;
        capture_word(8'hC3);
        exp_q.push_back(8'hC3);
        run_handshake(8'hC3, 4, 4, 1'b1);
        i_valid = 1'b0;
        tick;
        vectors++;
        if (o_busy !== 1'b0 || o_async_en !== 1'b0 || o_async_data !== 8'hC3) begin
            miscompares++;
            $display("FAIL ignored_end: busy=%b en=%b data=%h, want 0 0 c3", o_busy, o_async_en, o_async_data);
        end
    endtask

    task automatic test_stale_ack;
        i_rst = 1'b1;
        i_async_ack = 1'b1;
        tick;
        #2 i_rst = 1'b0;
        repeat (S) tick;
        i_data = 8'h99;
        i_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            vectors++;
            if (o_ready !== 1'b0 || o_async_en !== 1'b0 || o_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL stale_hold: ready=%b en=%b busy=%b, want 0 0 0", o_ready, o_async_en, o_busy);
            end
        end
        i_valid = 1'b0;
        i_async_ack = 1'b0;
        for (int i = 0; i <= S; i++) begin
            tick;
            vectors++;
            if ((i < S - 1 && o_ready !== 1'b0) || (i == S && o_ready !== 1'b1) || o_async_en !== 1'b0) begin
                miscompares++;
                $display("FAIL stale_release: edge=%0d ready=%b en=%b", i, o_ready, o_async_en);
            end
        end
    endtask

    task automatic test_mid_reset;
        capture_word(8'h77);
        tick;
        #2 i_rst = 1'b1;
        #1;
        vectors++;
        if (o_async_en !== 1'b0 || o_async_data !== 8'h00 || o_busy !== 1'b0 || o_ready !== 1'b1 || o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: en=%b data=%h busy=%b ready=%b done=%b, want 0 00 0 1 0", o_async_en, o_async_data, o_busy, o_ready, o_done);
        end
        tick;
        #2 i_rst = 1'b0;
        capture_word(8'h5A);
        exp_q.push_back(8'h5A);
        run_handshake(8'h5A, 3, 3, 1'b0);
        tick;
        vectors++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_end: done=%b busy=%b, want 0 0", o_done, o_busy);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] d;
        for (int t = 0; t < 12; t++) begin
            i_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick;
            d = W'($urandom);
            capture_word(d);
            exp_q.push_back(d);
            run_handshake(d, int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), 1'($urandom));
        end
        i_valid = 1'b0;
        tick;
    endtask

    task automatic test_order;
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL order_count: got %0d words, want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL order[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_ignored_input;
        test_stale_ack;
        test_mid_reset;
        test_random;
        test_order;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
